// File: rtl/usb_tx_serializer_if.sv
// usb_tx_serializer_if: protocol-controller and TX FIFO side of the USB full-speed transmitter
interface usb_tx_serializer_if #(
    parameter int OCC_W = 7
);
    logic [2:0]       tx_packet;
    logic [7:0]       tx_packet_data;
    logic [OCC_W-1:0] buffer_occupancy;
    logic             get_tx_packet_data;
    logic             tx_transfer_active;
    logic             tx_error;
    modport master (
        output tx_packet, tx_packet_data, buffer_occupancy,
        input  get_tx_packet_data, tx_transfer_active, tx_error
    );
    modport slave (
        input  tx_packet, tx_packet_data, buffer_occupancy,
        output get_tx_packet_data, tx_transfer_active, tx_error
    );
endinterface

// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer: USB full-speed packet transmitter with CRC16, bit stuffing, NRZI and EOP generation
module usb_tx_serializer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_BYTES    = 64,
    parameter int OCC_W        = 7,
    parameter bit STUFF_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    usb_tx_serializer_if.slave    bus,
    output logic                  dplus_out,
    output logic                  dminus_out
);
    localparam int DW = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J} state_t;
    state_t           state, nxt;
    logic [DW-1:0]    div;
    logic [2:0]       bit_cnt;
    logic [2:0]       ones;
    logic             stuff;
    logic             lvl;
    logic [7:0]       sr, nsr, pid, pid_sel;
    logic             is_data, data_cmd, accept, pop, stuff_now, nl;
    logic [OCC_W-1:0] remaining;
    logic [15:0]      crc, crc_nx;
    assign data_cmd  = bus.tx_packet == 3'd1 || bus.tx_packet == 3'd2;
    assign accept    = bus.tx_packet <= 3'd5 && !(data_cmd && int'(bus.buffer_occupancy) > MAX_BYTES);
    assign pid_sel   = bus.tx_packet == 3'd1 ? 8'hC3 :
                       bus.tx_packet == 3'd2 ? 8'h4B :
                       bus.tx_packet == 3'd3 ? 8'hD2 :
                       bus.tx_packet == 3'd4 ? 8'h5A : 8'h1E;
    assign stuff_now = STUFF_EN && !stuff && ones == 3'd6;
    assign nl        = nsr[0] ? lvl : !lvl;
    // Outcome of leaving the current data bit: next shift contents, next field and FIFO pop
    always_comb begin
        crc_nx = (crc[0] ^ sr[0]) ? (crc >> 1) ^ 16'hA001 : crc >> 1;
        nxt    = state;
        nsr    = {1'b0, sr[7:1]};
        pop    = 1'b0;
        if (bit_cnt == 3'd7) begin
            case (state)
                SYNC: begin
                    nxt = PID;
                    nsr = pid;
                end
                PID: begin
                    nxt = !is_data ? EOP_SE0 : (remaining == '0 ? CRC_LO : DATA);
                    nsr = remaining == '0 ? ~crc[7:0] : bus.tx_packet_data;
                    pop = remaining != '0;
                end
                DATA: begin
                    nxt = remaining == '0 ? CRC_LO : DATA;
                    nsr = remaining == '0 ? ~crc_nx[7:0] : bus.tx_packet_data;
                    pop = remaining != '0;
                end
                CRC_LO: begin
                    nxt = CRC_HI;
                    nsr = ~crc[15:8];
                end
                default: nxt = EOP_SE0;
            endcase
        end
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state                  <= IDLE;
            div                    <= '0;
            bit_cnt                <= '0;
            ones                   <= '0;
            stuff                  <= 1'b0;
            lvl                    <= 1'b1;
            sr                     <= '0;
            pid                    <= '0;
            is_data                <= 1'b0;
            remaining              <= '0;
            crc                    <= '1;
            dplus_out              <= 1'b1;
            dminus_out             <= 1'b0;
            bus.get_tx_packet_data <= 1'b0;
            bus.tx_transfer_active <= 1'b0;
            bus.tx_error           <= 1'b0;
        end else begin
            bus.get_tx_packet_data <= 1'b0;
            bus.tx_error           <= 1'b0;
            if (state == IDLE) begin
                dplus_out  <= 1'b1;
                dminus_out <= 1'b0;
                lvl        <= 1'b1;
                if (bus.tx_packet != 3'd0 && !accept) bus.tx_error <= 1'b1;
                else if (bus.tx_packet != 3'd0) begin
                    // First SYNC bit (0) goes on the line at the accepting edge: J to K
                    state                  <= SYNC;
                    bus.tx_transfer_active <= 1'b1;
                    div                    <= '0;
                    bit_cnt                <= '0;
                    ones                   <= '0;
                    stuff                  <= 1'b0;
                    sr                     <= 8'h80;
                    pid                    <= pid_sel;
                    is_data                <= data_cmd;
                    remaining              <= data_cmd ? bus.buffer_occupancy : '0;
                    crc                    <= '1;
                    lvl                    <= 1'b0;
                    dplus_out              <= 1'b0;
                    dminus_out             <= 1'b1;
                end
            end else if (div != DW'(CLKS_PER_BIT - 1)) div <= div + DW'(1);
            else begin
                div <= '0;
                if (state == EOP_SE0) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd1) begin
                        state      <= EOP_J;
                        lvl        <= 1'b1;
                        dplus_out  <= 1'b1;
                        dminus_out <= 1'b0;
                    end
                end else if (state == EOP_J) begin
                    state                  <= IDLE;
                    bus.tx_transfer_active <= 1'b0;
                end else if (stuff_now) begin
                    stuff      <= 1'b1;
                    ones       <= '0;
                    lvl        <= !lvl;
                    dplus_out  <= !lvl;
                    dminus_out <= lvl;
                end else begin
                    stuff   <= 1'b0;
                    state   <= nxt;
                    sr      <= nsr;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (state == DATA) crc <= crc_nx;
                    if (pop) begin
                        bus.get_tx_packet_data <= 1'b1;
                        remaining              <= remaining - OCC_W'(1);
                    end
                    if (nxt == EOP_SE0) begin
                        dplus_out  <= 1'b0;
                        dminus_out <= 1'b0;
                    end else begin
                        lvl        <= nl;
                        dplus_out  <= nl;
                        dminus_out <= !nl;
                        ones       <= nsr[0] ? ones + 3'd1 : 3'd0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb_usb_tx_serializer: table, random and directed checks of the USB transmitter against a waveform-level model
module tb_usb_tx_serializer;
    localparam int CPB  = 8;
    localparam int MAXB = 64;
    typedef struct {
        int cmd;
        int occ;
        bit sel;
        bit err;
    } vec_t;
    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    logic dp0, dm0, dp1, dm1;
    int total = 0;
    int bad   = 0;
    logic [1:0] cap[$];
    logic [1:0] exp_w[$];
    logic [7:0] fifo[$];
    logic [7:0] pay[$];
    int raw[$];
    int ds[$];
    int gets, errs, exp_stuffed;
    logic [15:0] exp_crc;
    bit idle_j, timed_out;
    vec_t tbl[9];
    usb_tx_serializer_if #(.OCC_W(7)) bus0 ();
    usb_tx_serializer_if #(.OCC_W(7)) bus1 ();
    usb_tx_serializer #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB), .OCC_W(7), .STUFF_EN(1'b1)) u_dut (
        .clk(clk), .n_rst(n_rst), .bus(bus0), .dplus_out(dp0), .dminus_out(dm0));
    usb_tx_serializer #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB), .OCC_W(7), .STUFF_EN(1'b0)) u_nostuff (
        .clk(clk), .n_rst(n_rst), .bus(bus1), .dplus_out(dp1), .dminus_out(dm1));
    always #5 clk = ~clk;
    function automatic logic [7:0] pid_of(input int cmd);
        return cmd == 1 ? 8'hC3 : cmd == 2 ? 8'h4B : cmd == 3 ? 8'hD2 : cmd == 4 ? 8'h5A : 8'h1E;
    endfunction
    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask
    task automatic emit(inout int lvl, input int b);
        lvl = b != 0 ? lvl : 1 - lvl;
        repeat (CPB) exp_w.push_back({lvl[0], ~lvl[0]});
    endtask
    // Expected line waveform for one whole packet, one entry per clock while active
    task automatic model(input bit stuff_en, input int cmd);
        logic [7:0] bytes[$];
        logic [15:0] c;
        int ones, lvl;
        c = 16'hFFFF;
        ones = 0;
        lvl = 1;
        bytes.push_back(8'h80);
        bytes.push_back(pid_of(cmd));
        if (cmd <= 2) begin
            foreach (pay[i]) begin
                bytes.push_back(pay[i]);
                for (int b = 0; b < 8; b++) c = (c[0] ^ pay[i][b]) ? (c >> 1) ^ 16'hA001 : c >> 1;
            end
            c = ~c;
            bytes.push_back(c[7:0]);
            bytes.push_back(c[15:8]);
        end
        exp_crc = c;
        exp_w.delete();
        exp_stuffed = 0;
        foreach (bytes[i]) begin
            for (int b = 0; b < 8; b++) begin
                emit(lvl, int'(bytes[i][b]));
                ones = bytes[i][b] ? ones + 1 : 0;
                if (stuff_en && ones == 6) begin
                    emit(lvl, 0);
                    ones = 0;
                    exp_stuffed++;
                end
            end
        end
        repeat (2 * CPB) exp_w.push_back(2'b00);
        repeat (CPB) exp_w.push_back(2'b10);
    endtask
    task automatic send(input bit sel, input int cmd, input int occ);
        @(negedge clk);
        fifo = pay;
        if (sel) begin
            bus1.tx_packet        = 3'(cmd);
            bus1.buffer_occupancy = 7'(occ);
        end else begin
            bus0.tx_packet        = 3'(cmd);
            bus0.buffer_occupancy = 7'(occ);
        end
        bus0.tx_packet_data = fifo.size() > 0 ? fifo[0] : 8'h00;
        bus1.tx_packet_data = bus0.tx_packet_data;
        @(posedge clk);
        #1;
        bus0.tx_packet = 3'd0;
        bus1.tx_packet = 3'd0;
        cap.delete();
        gets = 0;
        errs = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (sel ? bus1.tx_error : bus0.tx_error) errs++;
            if (!(sel ? bus1.tx_transfer_active : bus0.tx_transfer_active)) begin
                timed_out = 1'b0;
                break;
            end
            cap.push_back(sel ? {dp1, dm1} : {dp0, dm0});
            if (sel ? bus1.get_tx_packet_data : bus0.get_tx_packet_data) begin
                gets++;
                if (fifo.size() > 0) void'(fifo.pop_front());
                bus0.tx_packet_data = fifo.size() > 0 ? fifo[0] : 8'h00;
                bus1.tx_packet_data = bus0.tx_packet_data;
            end
        end
        idle_j = sel ? (dp1 && !dm1) : (dp0 && !dm0);
        @(negedge clk);
        if (sel ? bus1.tx_error : bus0.tx_error) errs++;
        chk("timeout", timed_out, 0);
    endtask
    task automatic decode(input bit stuff_en);
        int prev, ones, l;
        bit skip;
        prev = 1;
        ones = 0;
        skip = 1'b0;
        raw.delete();
        ds.delete();
        for (int k = 0; k < cap.size() / CPB - 3; k++) begin
            l = int'(cap[k * CPB + CPB / 2][1]);
            raw.push_back(l == prev ? 1 : 0);
            prev = l;
        end
        foreach (raw[k]) begin
            if (skip) begin
                skip = 1'b0;
                ones = 0;
            end else begin
                ds.push_back(raw[k]);
                ones = raw[k] != 0 ? ones + 1 : 0;
                if (stuff_en && ones == 6) begin
                    skip = 1'b1;
                    ones = 0;
                end
            end
        end
    endtask
    function automatic longint seq_val(input bit use_ds, input int start, input int n);
        longint v = 0;
        if (start + n > (use_ds ? ds.size() : raw.size())) return -1;
        for (int k = 0; k < n; k++) v = (v << 1) | longint'(use_ds ? ds[start + k] : raw[start + k]);
        return v;
    endfunction
    function automatic longint lsb_val(input bit use_ds, input int start, input int n);
        longint v = 0;
        if (start + n > (use_ds ? ds.size() : raw.size())) return -1;
        for (int k = 0; k < n; k++) v = v | (longint'(use_ds ? ds[start + k] : raw[start + k]) << k);
        return v;
    endfunction
    function automatic int wave_miss();
        int m = cap.size() > exp_w.size() ? cap.size() - exp_w.size() : exp_w.size() - cap.size();
        for (int i = 0; i < cap.size() && i < exp_w.size(); i++) if (cap[i] !== exp_w[i]) m++;
        return m;
    endfunction
    task automatic check_pkt(input bit sel, input int cmd, input int occ, input bit want_err);
        pay.delete();
        if (!want_err && cmd <= 2) repeat (occ) pay.push_back(8'($urandom));
        model(!sel, cmd);
        send(sel, cmd, occ);
        chk("err_pulse", errs, want_err);
        if (want_err) begin
            chk("rej_active_cycles", cap.size(), 0);
            chk("rej_idle_j", idle_j, 1);
        end else begin
            chk("length", cap.size(), exp_w.size());
            chk("wave", wave_miss(), 0);
            chk("gets", gets, cmd <= 2 ? occ : 0);
            chk("end_idle_j", idle_j, 1);
        end
    endtask
    initial begin
        int n, cmd, occ;
        bit sel;
        bus0.tx_packet = 3'd0;
        bus0.tx_packet_data = 8'h00;
        bus0.buffer_occupancy = 7'd0;
        bus1.tx_packet = 3'd0;
        bus1.tx_packet_data = 8'h00;
        bus1.buffer_occupancy = 7'd0;
        tbl[0] = '{3, 0, 1'b0, 1'b0};
        tbl[1] = '{4, 0, 1'b0, 1'b0};
        tbl[2] = '{5, 0, 1'b0, 1'b0};
        tbl[3] = '{1, 3, 1'b0, 1'b0};
        tbl[4] = '{2, 64, 1'b0, 1'b0};
        tbl[5] = '{1, 65, 1'b0, 1'b1};
        tbl[6] = '{6, 0, 1'b0, 1'b1};
        tbl[7] = '{7, 5, 1'b0, 1'b1};
        tbl[8] = '{2, 5, 1'b1, 1'b0};
        @(negedge clk);
        chk("rst_dplus", dp0, 1);
        chk("rst_dminus", dm0, 0);
        chk("rst_active", bus0.tx_transfer_active, 0);
        chk("rst_get", bus0.get_tx_packet_data, 0);
        chk("rst_error", bus0.tx_error, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        pay.delete();
        model(1'b1, 3);
        send(1'b0, 3, 0);
        decode(1'b1);
        chk("ack_len", cap.size(), 152);
        chk("ack_gets", gets, 0);
        chk("ack_bits", seq_val(1'b0, 0, 16), 16'b0000_0001_0100_1011);
        n = 0;
        foreach (cap[i]) if (cap[i] == 2'b00) n++;
        chk("ack_se0_cycles", n, 16);
        n = 0;
        foreach (cap[i]) if (i >= 144 && i < 152 && cap[i] == 2'b10) n++;
        chk("ack_j_tail", n, 8);
        chk("ack_wave", wave_miss(), 0);
        pay.delete();
        model(1'b1, 2);
        send(1'b0, 2, 0);
        decode(1'b1);
        chk("d1_len", cap.size(), 280);
        chk("d1_gets", gets, 0);
        chk("d1_pid_bits", seq_val(1'b0, 8, 8), 8'b1101_0010);
        chk("d1_crc", lsb_val(1'b0, 16, 16), 0);
        chk("d1_raw_bits", raw.size(), 32);
        chk("d1_wave", wave_miss(), 0);
        pay.delete();
        pay.push_back(8'hFF);
        model(1'b1, 1);
        send(1'b0, 1, 1);
        decode(1'b1);
        chk("ff_gets", gets, 1);
        chk("ff_stuff_pos", seq_val(1'b0, 16, 5), 5'b11110);
        chk("ff_crc", lsb_val(1'b1, 24, 16), exp_crc);
        chk("ff_wave", wave_miss(), 0);
        pay.delete();
        pay.push_back(8'hFF);
        model(1'b0, 1);
        send(1'b1, 1, 1);
        decode(1'b0);
        chk("ns_gets", gets, 1);
        chk("ns_no_stuff", seq_val(1'b0, 16, 5), 5'b11111);
        chk("ns_len", cap.size(), 344);
        chk("ns_crc", lsb_val(1'b0, 24, 16), exp_crc);
        chk("ns_wave", wave_miss(), 0);
        foreach (tbl[i]) check_pkt(tbl[i].sel, tbl[i].cmd, tbl[i].occ, tbl[i].err);
        for (int i = 0; i < 12; i++) begin
            cmd = $urandom_range(1, 7);
            occ = $urandom_range(0, 3) == 0 ? $urandom_range(60, 70) : $urandom_range(0, 20);
            sel = 1'($urandom_range(0, 1));
            check_pkt(sel, cmd, occ, cmd > 5 || (cmd <= 2 && occ > MAXB));
        end
        pay.delete();
        repeat (4) pay.push_back(8'($urandom));
        @(negedge clk);
        bus0.tx_packet = 3'd1;
        bus0.buffer_occupancy = 7'd4;
        bus0.tx_packet_data = pay[0];
        @(posedge clk);
        #1;
        bus0.tx_packet = 3'd0;
        repeat (300) @(negedge clk);
        chk("mid_active", bus0.tx_transfer_active, 1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_dplus", dp0, 1);
        chk("mid_rst_dminus", dm0, 0);
        chk("mid_rst_active", bus0.tx_transfer_active, 0);
        chk("mid_rst_get", bus0.get_tx_packet_data, 0);
        @(negedge clk);
        n_rst = 1'b1;
        pay.delete();
        model(1'b1, 3);
        send(1'b0, 3, 0);
        chk("post_rst_ack_len", cap.size(), 152);
        chk("post_rst_ack_wave", wave_miss(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/usb_tx_serializer.md
# usb_tx_serializer

Parametrised USB full-speed packet transmitter: the next-generation replacement for the team's fixed 8-clock, no-stuffing transmitter. It builds SYNC, PID, payload, CRC16 and EOP from a packet command and the TX FIFO. It applies bit stuffing and NRZI encoding, and drives the differential D+/D- pair. It sits between the protocol controller (tx_packet), the TX data buffer (tx_packet_data, buffer_occupancy) and the USB line drivers.

## Interface
Parameters:
- CLKS_PER_BIT, 8, clk cycles per USB bit time; must be ≥ 2.
- MAX_BYTES, 64, largest data payload accepted.
- OCC_W, 7, width of buffer_occupancy.
- STUFF_EN, 1, 1 enables bit stuffing; 0 disables it (test/debug mode).

Ports:
- clk  in  1  system clock; the block uses this single clock.
- n_rst  in  1  asynchronous, active-low reset.
- tx_packet  in  3  command: 0 idle, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6–7 reserved.
- tx_packet_data  in  8  FIFO head byte; valid combinationally; the FIFO pops on get_tx_packet_data.
- buffer_occupancy  in  OCC_W  bytes in the FIFO; sampled at packet start.
- get_tx_packet_data  out  1  one-cycle pop strobe for the FIFO.
- tx_transfer_active  out  1  high for the whole packet, SYNC first bit through EOP end.
- tx_error  out  1  one-cycle pulse when a command is rejected.
- dplus_out  out  1  D+ line.
- dminus_out  out  1  D- line.

## Operation
- **States:** IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J.
- **IDLE:**
  - Lines drive J (dplus=1, dminus=0).
  - A nonzero tx_packet is sampled on a clk edge.
  - A valid command latches the PID byte (DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E) and moves to SYNC.
  - For DATA packets it also latches byte_count = buffer_occupancy.
- **Rejected commands:**
  - Rejection applies to reserved codes, and to DATA with buffer_occupancy > MAX_BYTES.
  - The block pulses tx_error for one cycle and stays in IDLE.
  - No line activity occurs.
- **Field order:**
  - SYNC sends 0x80.
  - PID sends the latched PID byte.
  - Handshake packets (ACK, NAK, STALL) go from PID straight to EOP_SE0.
  - DATA packets send byte_count bytes, then CRC_LO, then CRC_HI.
  - byte_count = 0 skips DATA.
- **Bit order:** every byte is sent LSB first.
- **FIFO reads:**
  - get_tx_packet_data pulses in the cycle each payload byte is loaded into the shift register.
  - tx_packet_data is captured in that same cycle.
  - There are exactly byte_count pulses per packet.
- **CRC16:**
  - Polynomial x^16+x^15+x^2+1, initial value 0xFFFF.
  - Updated over payload bits only, LSB first.
  - The transmitted value is the ones-complement.
  - The low byte is sent first, each byte LSB first.
- **Bit stuffing:**
  - A ones counter runs over raw bits from SYNC through CRC_HI.
  - After six consecutive 1s, one 0 bit is inserted.
  - During the inserted bit, the data shift register and CRC hold.
  - The counter resets on any 0, including a stuffed 0.
  - A stuff pending after the last CRC bit is still sent before EOP.
  - STUFF_EN=0 disables insertion entirely.
- **NRZI:**
  - A 0 bit toggles the line state; a 1 bit holds it.
  - The line state resets to J.
  - Differential drive: dminus_out = !dplus_out.
- **EOP:**
  - EOP_SE0 drives dplus=dminus=0 for 2 bit times.
  - EOP_J drives J for 1 bit time, then the block returns to IDLE.
  - The NRZI state is reset to J.
- **Mid-packet commands:** tx_packet is ignored while tx_transfer_active=1.

## Timing
- **Reset values:**
  - get_tx_packet_data=0, tx_transfer_active=0, tx_error=0, dplus_out=1, dminus_out=0.
  - State=IDLE; ones counter, bit counter and clk divider all 0.
- **Reset mid-packet:** all of the above take effect immediately (asynchronous) and the packet is abandoned.
- **Start latency:**
  - Command sampled at edge N.
  - tx_transfer_active=1 and the first SYNC bit are on the lines from edge N; the first edge is a J→K toggle.
- **Bit timing:** each bit, stuffed bits included, is held for exactly CLKS_PER_BIT cycles; a divider count of CLKS_PER_BIT−1 advances to the next bit.
- **Packet length:**
  - Duration = CLKS_PER_BIT × (16 + 8·byte_count + 16·isData + stuffed_bits + 3) cycles.
  - tx_transfer_active falls on the edge that ends EOP_J.
- **Back-to-back commands:** a new command may be accepted in the first IDLE cycle after tx_transfer_active falls.
- **tx_error timing:** asserted the cycle after the rejected command edge, for 1 cycle.
- **Outputs:** dplus_out and dminus_out are registered; there are no combinational paths from inputs to the lines.

## Test plan
- **Reset:** n_rst low → dplus=1, dminus=0, active=0, get=0, error=0.
- **ACK:** ACK at CLKS_PER_BIT=8 → active high for exactly 152 cycles; NRZI-decoded bits are 0000_0001 then 0100_1011; SE0 for 16 cycles, J for 8; zero get pulses.
- **Empty DATA1:** DATA1 with occupancy 0 → 280 active cycles; decoded PID bits 1101_0010; CRC field 0x0000; no stuffing; zero get pulses.
- **DATA0 stuffing:** DATA0 with occupancy 1 and byte 0xFF → exactly 1 get pulse; a stuffed 0 follows the 4th payload bit; the decoded and de-stuffed CRC matches the bench model. With STUFF_EN=0 there is no stuffed bit.
- **Rejected commands:**
  - tx_packet=6 → 1-cycle tx_error, lines stay J, active stays 0.
  - DATA0 with occupancy 65 at MAX_BYTES=64 → same response.
- **Reset mid-packet:** n_rst asserted halfway through a DATA payload → lines return to J asynchronously; the next ACK command transmits correctly.
